shift_sequencer: RTL and testbench



---
 rtl/shift_sequencer_if.sv | 23 ++
 rtl/shift_sequencer.sv | 161 ++++++++++++++++
 tb/tb_shift_sequencer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/shift_sequencer_if.sv
// shift_sequencer_if: request/result bundle between the CPU control FSM
// (master) and the multi-cycle shift sequencer (slave).
interface shift_sequencer_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic [WIDTH-1:0] in;
    logic [5:0]       shamt;
    logic [1:0]       op;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;

    modport master (
        output start, in, shamt, op,
        input  busy, done, out
    );

    modport slave (
        input  start, in, shamt, op,
        output busy, done, out
    );
endinterface

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle 64-bit LSL/LSR/ASR for the LEGv8 datapath.
// One binary-weighted stage (1,2,4,8,16,32) is applied per clock from a
// single registered data word, so only a 6:1 mux of fixed shifts sits
// between flops instead of a six-level barrel shifter.
//
// Build option SHIFT_SKIP_EN: when defined, each cycle applies only the
// lowest set bit of the remaining shift mask and completes as soon as the
// mask empties (latency max(1, popcount(shamt))). When undefined, every
// stage is visited and latency is a fixed 6 cycles. Results are identical.
//
// WIDTH must stay 64 (shamt is fixed at 6 bits); NSTAGE is log2(WIDTH).

// One fixed-distance shift candidate. op: 00=LSL, 10=ASR, 01/11=LSR.
module shift_sequencer_stage #(
    parameter int WIDTH = 64,
    parameter int SH    = 1
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    // Fixed shift by SH with the fill selected by op
    always_comb begin
        case (op)
            2'b00:   q = {d[WIDTH-1-SH:0], {SH{1'b0}}};
            2'b10:   q = {{SH{d[WIDTH-1]}}, d[WIDTH-1:SH]};
            default: q = {{SH{1'b0}}, d[WIDTH-1:SH]};
        endcase
    end
endmodule

module shift_sequencer #(
    parameter int WIDTH  = 64,
    parameter int NSTAGE = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    shift_sequencer_if.slave  bus
);
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0]             data;
    logic [WIDTH-1:0]             data_nxt;
    logic [WIDTH-1:0]             out_q;
    logic [NSTAGE-1:0]            mask;
    logic [NSTAGE-1:0]            mask_nxt;
    logic [1:0]                   op_q;
    logic                         done_q;
    logic [2:0]                   sel;
    logic                         apply;
    logic                         last;
    logic                         accept;
    logic                         finish;
    logic [NSTAGE-1:0][WIDTH-1:0] stg;
`ifndef SHIFT_SKIP_EN
    logic [2:0]                   idx;
`endif

    // All six fixed-distance candidates of the held data word
    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        shift_sequencer_stage #(
            .WIDTH (WIDTH),
            .SH    (1 << k)
        ) u_stage (
            .op (op_q),
            .d  (data),
            .q  (stg[k])
        );
    end

    // Pick this cycle's stage, whether it applies, and whether it is the last
    always_comb begin
`ifdef SHIFT_SKIP_EN
        // Lowest set bit of the remaining mask is the stage to apply now
        sel = '0;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (mask[k]) sel = 3'(k);
        end
        apply    = |mask;
        mask_nxt = mask & (mask - NSTAGE'(1));
        last     = (mask_nxt == '0);
`else
        sel      = idx;
        apply    = mask[idx];
        mask_nxt = mask;
        last     = (idx == 3'(NSTAGE - 1));
`endif
        data_nxt = apply ? stg[sel] : data;
    end

    // Control FSM: next state and handshake strobes
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (last) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register; reset aborts any in-flight operation
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Operand capture, per-stage update and result/done registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data   <= '0;
            mask   <= '0;
            op_q   <= '0;
            out_q  <= '0;
            done_q <= 1'b0;
`ifndef SHIFT_SKIP_EN
            idx    <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                data <= bus.in;
                mask <= bus.shamt;
                op_q <= bus.op;
`ifndef SHIFT_SKIP_EN
                idx  <= '0;
`endif
            end else if (state == SHIFT) begin
                data <= data_nxt;
                mask <= mask_nxt;
`ifndef SHIFT_SKIP_EN
                idx  <= idx + 3'd1;
`endif
                if (finish) begin
                    out_q  <= data_nxt;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign bus.busy = (state == SHIFT);
    assign bus.done = done_q;
    assign bus.out  = out_q;
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed and randomized checks of shift_sequencer
// against an arithmetic reference (<<, >>, >>>) and a latency model.
module tb_shift_sequencer;
    logic clk;
    logic reset_n;
    int   vectors;
    int   miscompares;

    shift_sequencer_if bus ();

    shift_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_shift(input logic [63:0] a, input logic [5:0] s,
                                              input logic [1:0] o);
        logic [63:0] r;
        case (o)
            2'b00:   r = a << s;
            2'b10:   r = $signed(a) >>> s;
            default: r = a >> s;
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [5:0] s);
`ifdef SHIFT_SKIP_EN
        return ($countones(s) == 0) ? 1 : $countones(s);
`else
        return 6;
`endif
    endfunction

    // Issue one request, scramble the inputs after acceptance, and wait for done.
    // lat counts edges after the accepting edge; 20 means the bound expired.
    task automatic run_op(input logic [63:0] a, input logic [5:0] s, input logic [1:0] o,
                          output logic [63:0] res, output int lat);
        @(negedge clk);
        bus.start = 1'b1; bus.in = a; bus.shamt = s; bus.op = o;
        @(negedge clk);
        bus.start = 1'b0; bus.in = {$urandom, $urandom};
        bus.shamt = 6'($urandom); bus.op = 2'($urandom);
        lat = 0;
        while (bus.done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        res = bus.out;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.start = 1'b0; bus.in = '0; bus.shamt = '0; bus.op = '0;
        repeat (2) @(negedge clk);
        vectors++;
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        vectors++;
        if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", bus.done); end
        vectors++;
        if (bus.out !== 64'h0) begin miscompares++; $display("FAIL reset_out: got %h want 0", bus.out); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_lsr();
        logic [63:0] r;
        int lat;
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 6'd32, 2'b01, r, lat);
        vectors++;
        if (r !== 64'h0000_0000_FFFF_FFFF) begin miscompares++; $display("FAIL lsr_out: got %h want %h", r, 64'h0000_0000_FFFF_FFFF); end
        vectors++;
        if (lat != ref_lat(6'd32)) begin miscompares++; $display("FAIL lsr_lat: got %0d want %0d", lat, ref_lat(6'd32)); end
        @(negedge clk);
        vectors++;
        if (bus.done !== 1'b0) begin miscompares++; $display("FAIL done_width: got %b want 0", bus.done); end
        vectors++;
        if (bus.out !== 64'h0000_0000_FFFF_FFFF) begin miscompares++; $display("FAIL out_hold: got %h want %h", bus.out, 64'h0000_0000_FFFF_FFFF); end
    endtask

    task automatic test_lsl_asr();
        logic [63:0] r;
        int lat;
        run_op(64'h1, 6'd63, 2'b00, r, lat);
        vectors++;
        if (r !== 64'h8000_0000_0000_0000) begin miscompares++; $display("FAIL lsl63_out: got %h want %h", r, 64'h8000_0000_0000_0000); end
        vectors++;
        if (lat != ref_lat(6'd63)) begin miscompares++; $display("FAIL lsl63_lat: got %0d want %0d", lat, ref_lat(6'd63)); end
        run_op(64'h8000_0000_0000_0000, 6'd4, 2'b10, r, lat);
        vectors++;
        if (r !== 64'hF800_0000_0000_0000) begin miscompares++; $display("FAIL asr4_out: got %h want %h", r, 64'hF800_0000_0000_0000); end
        run_op(64'h8000_0000_0000_0000, 6'd63, 2'b10, r, lat);
        vectors++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin miscompares++; $display("FAIL asr63_out: got %h want all ones", r); end
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 6'd63, 2'b11, r, lat);
        vectors++;
        if (r !== 64'h1) begin miscompares++; $display("FAIL rsvd63_out: got %h want 1", r); end
    endtask

    task automatic test_busy_ignore();
        logic [63:0] a;
        logic [5:0]  s;
        logic [1:0]  o;
        int lat;
        a = {$urandom, $urandom}; s = 6'($urandom); o = 2'($urandom);
        @(negedge clk);
        bus.start = 1'b1; bus.in = a; bus.shamt = s; bus.op = o;
        @(negedge clk);
        lat = 0;
        while (bus.done !== 1'b1 && lat < 20) begin
            bus.start = 1'b1; bus.in = {$urandom, $urandom};
            bus.shamt = 6'($urandom); bus.op = 2'($urandom);
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
        vectors++;
        if (bus.out !== ref_shift(a, s, o)) begin miscompares++; $display("FAIL busy_out: got %h want %h", bus.out, ref_shift(a, s, o)); end
        vectors++;
        if (lat != ref_lat(s)) begin miscompares++; $display("FAIL busy_lat: got %0d want %0d", lat, ref_lat(s)); end
        @(negedge clk);
        vectors++;
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL busy_noqueue: got %b want 0", bus.busy); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] a;
        logic [5:0]  s;
        int lat;
        a = {$urandom, $urandom}; s = 6'($urandom);
        @(negedge clk);
        bus.start = 1'b1; bus.in = a; bus.shamt = s; bus.op = 2'b00;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
        vectors++;
        if (bus.out !== ref_shift(a, s, 2'b00)) begin miscompares++; $display("FAIL b2b_first: got %h want %h", bus.out, ref_shift(a, s, 2'b00)); end
        bus.start = 1'b1; bus.in = 64'hF0; bus.shamt = 6'd4; bus.op = 2'b01;
        @(negedge clk);
        bus.start = 1'b0; bus.in = '1; bus.shamt = 6'd1; bus.op = 2'b00;
        vectors++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin miscompares++; $display("FAIL b2b_accept: got done=%b busy=%b want done=0 busy=1", bus.done, bus.busy); end
        lat = 0;
        while (bus.done !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
        vectors++;
        if (bus.out !== 64'hF) begin miscompares++; $display("FAIL b2b_out: got %h want f", bus.out); end
        vectors++;
        if (lat != ref_lat(6'd4)) begin miscompares++; $display("FAIL b2b_lat: got %0d want %0d", lat, ref_lat(6'd4)); end
    endtask

    task automatic test_shamt_zero();
        logic [63:0] r;
        int lat;
        run_op(64'h1234_5678_9ABC_DEF0, 6'd0, 2'($urandom), r, lat);
        vectors++;
        if (r !== 64'h1234_5678_9ABC_DEF0) begin miscompares++; $display("FAIL zero_out: got %h want %h", r, 64'h1234_5678_9ABC_DEF0); end
        vectors++;
        if (lat != ref_lat(6'd0)) begin miscompares++; $display("FAIL zero_lat: got %0d want %0d", lat, ref_lat(6'd0)); end
    endtask

    task automatic test_skip_latency();
        logic [63:0] r;
        int lat;
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 6'b100001, 2'b01, r, lat);
        vectors++;
        if (r !== 64'h0000_0000_7FFF_FFFF) begin miscompares++; $display("FAIL skip_out: got %h want %h", r, 64'h0000_0000_7FFF_FFFF); end
        vectors++;
        if (lat != ref_lat(6'b100001)) begin miscompares++; $display("FAIL skip_lat: got %0d want %0d", lat, ref_lat(6'b100001)); end
    endtask

    task automatic test_random();
        logic [63:0] a, r;
        logic [5:0]  s;
        logic [1:0]  o;
        int lat;
        for (int i = 0; i < 40; i++) begin
            a = {$urandom, $urandom}; s = 6'($urandom); o = 2'($urandom);
            if (i % 4 == 0) a[63] = 1'b1;
            run_op(a, s, o, r, lat);
            vectors++;
            if (r !== ref_shift(a, s, o)) begin miscompares++; $display("FAIL rand_out[%0d]: got %h want %h (op=%0d shamt=%0d)", i, r, ref_shift(a, s, o), o, s); end
            vectors++;
            if (lat != ref_lat(s)) begin miscompares++; $display("FAIL rand_lat[%0d]: got %0d want %0d", i, lat, ref_lat(s)); end
        end
    endtask

    task automatic test_reset_midop();
        int pulses;
        logic [5:0] s;
`ifdef SHIFT_SKIP_EN
        s = 6'h3F;
`else
        s = 6'd32;
`endif
        @(negedge clk);
        bus.start = 1'b1; bus.in = '1; bus.shamt = s; bus.op = 2'b01;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.out !== 64'h0) begin
            miscompares++;
            $display("FAIL midop_reset: got busy=%b done=%b out=%h want 0/0/0", bus.busy, bus.done, bus.out);
        end
        @(negedge clk);
        reset_n = 1'b1;
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done === 1'b1) pulses++;
        end
        vectors++;
        if (pulses != 0) begin miscompares++; $display("FAIL midop_nodone: got %0d done pulses want 0", pulses); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_lsr();
        test_lsl_asr();
        test_busy_ignore();
        test_back_to_back();
        test_shamt_zero();
        test_skip_latency();
        test_random();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
